// File: rtl/worker_unit.sv
// Matrix worker: computes one C[row][col] dot product over a shared A/B memory.
// Build option: define WORKER_SATURATE_EN for saturating accumulation (default wraps).
module worker_unit #(
    parameter int unsigned UNIT_ID = 0,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [31:0]       i_Config,
    input  logic [3:0]        i_Indexes_Ready,
    input  logic [7:0]        i_Row_Index,
    input  logic [7:0]        i_Column_Index,
    output logic              o_Indexes_Received,
    output logic [ADDR_W-1:0] o_A_Addr,
    input  logic [31:0]       i_A_Data,
    output logic [ADDR_W-1:0] o_B_Addr,
    input  logic [31:0]       i_B_Data,
    output logic [31:0]       o_Result,
    output logic [7:0]        o_Result_Row,
    output logic [7:0]        o_Result_Column,
    output logic              o_Result_Ready,
    input  logic              i_Result_Taken,
    output logic              o_Error
);

    localparam logic [1:0] LP_SEL = UNIT_ID[1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic [7:0]  r_k_len;
    logic [7:0]  r_b_cols;
    logic [7:0]  r_k;
    logic        r_err;
    logic        r_ack;
    logic        r_pend;
    logic [31:0] r_acc;

    logic        w_req;
    logic        w_capture;
    logic [7:0]  w_cfg_a_rows;
    logic [7:0]  w_cfg_k;
    logic [7:0]  w_cfg_b_rows;
    logic [7:0]  w_cfg_b_cols;
    logic        w_cfg_bad;
    logic        w_last_k;
    logic        w_done;
    logic [31:0] w_a_addr_full;
    logic [31:0] w_b_addr_full;
    logic [31:0] w_acc_next;

    assign w_req        = i_Indexes_Ready[LP_SEL];
    assign w_capture    = (r_state == IDLE) && w_req;

    assign w_cfg_a_rows = i_Config[31:24];
    assign w_cfg_k      = i_Config[23:16];
    assign w_cfg_b_rows = i_Config[15:8];
    assign w_cfg_b_cols = i_Config[7:0];

    // Mismatched inner dimensions are reported the same way as bad indexes.
    assign w_cfg_bad    = (i_Row_Index >= w_cfg_a_rows) ||
                          (i_Column_Index >= w_cfg_b_cols) ||
                          (w_cfg_k != w_cfg_b_rows);

    assign w_last_k     = (r_k == (r_k_len - 8'd1));
    assign w_done       = (r_state == DONE);

    // ------------------------------------------------------------------
    // Accumulate datapath
    // ------------------------------------------------------------------
`ifdef WORKER_SATURATE_EN
    localparam logic signed [64:0] LP_MAX = 65'sd2147483647;
    localparam logic signed [64:0] LP_MIN = -65'sd2147483648;

    logic signed [63:0] w_prod;
    logic signed [64:0] w_sum;

    assign w_prod = $signed(i_A_Data) * $signed(i_B_Data);
    assign w_sum  = $signed({w_prod[63], w_prod}) + $signed({{33{r_acc[31]}}, r_acc});

    always_comb begin
        w_acc_next = w_sum[31:0];
        if (w_sum > LP_MAX) begin
            w_acc_next = 32'h7FFF_FFFF;
        end else if (w_sum < LP_MIN) begin
            w_acc_next = 32'h8000_0000;
        end
    end
`else
    logic [31:0] w_prod;

    // Low 32 bits of a signed product equal those of the unsigned product.
    assign w_prod     = i_A_Data * i_B_Data;
    assign w_acc_next = r_acc + w_prod;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_cfg_bad || (w_cfg_k == 8'd0)) begin
                        w_next_state = DRAIN;
                    end else begin
                        w_next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                if (w_last_k) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = DONE;
            end
            DONE: begin
                if (i_Result_Taken) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_row    <= '0;
            r_col    <= '0;
            r_k_len  <= '0;
            r_b_cols <= '0;
            r_k      <= '0;
            r_err    <= 1'b0;
            r_ack    <= 1'b0;
            r_pend   <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_ack  <= w_capture;
            // Read data returns one cycle after each FETCH address.
            r_pend <= (r_state == FETCH);
            if (w_capture) begin
                r_row    <= i_Row_Index;
                r_col    <= i_Column_Index;
                r_k_len  <= w_cfg_k;
                r_b_cols <= w_cfg_b_cols;
                r_k      <= '0;
                r_err    <= w_cfg_bad;
                r_acc    <= '0;
            end else begin
                if (r_state == FETCH) begin
                    r_k <= r_k + 8'd1;
                end
                if (r_pend) begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_a_addr_full      = 32'(r_row) * 32'(r_k_len) + 32'(r_k);
    assign w_b_addr_full      = 32'(r_k) * 32'(r_b_cols) + 32'(r_col);

    assign o_A_Addr           = (r_state == FETCH) ? w_a_addr_full[ADDR_W-1:0] : '0;
    assign o_B_Addr           = (r_state == FETCH) ? w_b_addr_full[ADDR_W-1:0] : '0;

    assign o_Indexes_Received = r_ack;
    assign o_Result_Ready     = w_done;
    assign o_Result           = w_done ? r_acc : '0;
    assign o_Result_Row       = w_done ? r_row : '0;
    assign o_Result_Column    = w_done ? r_col : '0;
    assign o_Error            = w_done & r_err;

endmodule

// File: tb/tb_worker_unit.sv
// Directed self-checking bench for worker_unit (UNIT_ID=0, ADDR_W=16).
module tb_worker_unit;

    logic        i_Clock;
    logic        i_Reset;
    logic [31:0] i_Config;
    logic [3:0]  i_Indexes_Ready;
    logic [7:0]  i_Row_Index;
    logic [7:0]  i_Column_Index;
    logic        o_Indexes_Received;
    logic [15:0] o_A_Addr;
    logic [31:0] i_A_Data;
    logic [15:0] o_B_Addr;
    logic [31:0] i_B_Data;
    logic [31:0] o_Result;
    logic [7:0]  o_Result_Row;
    logic [7:0]  o_Result_Column;
    logic        o_Result_Ready;
    logic        i_Result_Taken;
    logic        o_Error;

    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    worker_unit #(
        .UNIT_ID (0),
        .ADDR_W  (16)
    ) dut (
        .i_Clock            (i_Clock),
        .i_Reset            (i_Reset),
        .i_Config           (i_Config),
        .i_Indexes_Ready    (i_Indexes_Ready),
        .i_Row_Index        (i_Row_Index),
        .i_Column_Index     (i_Column_Index),
        .o_Indexes_Received (o_Indexes_Received),
        .o_A_Addr           (o_A_Addr),
        .i_A_Data           (i_A_Data),
        .o_B_Addr           (o_B_Addr),
        .i_B_Data           (i_B_Data),
        .o_Result           (o_Result),
        .o_Result_Row       (o_Result_Row),
        .o_Result_Column    (o_Result_Column),
        .o_Result_Ready     (o_Result_Ready),
        .i_Result_Taken     (i_Result_Taken),
        .o_Error            (o_Error)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    // Synchronous memory model: data one cycle after address.
    always @(posedge i_Clock) begin
        i_A_Data <= mem_a[o_A_Addr[3:0]];
        i_B_Data <= mem_b[o_B_Addr[3:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge i_Clock);
    endtask

    task automatic load_3x3();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = (i < 9) ? 32'(i + 1) : 32'h0;
            mem_b[i] = (i < 9) ? 32'(i + 1) : 32'h0;
        end
        i_Config = 32'h0303_0303;
    endtask

    task automatic take_result();
        i_Result_Taken = 1'b1;
        tick();
        i_Result_Taken = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset = 1'b0;
        i_Indexes_Ready = 4'b0000;
        i_Row_Index = 8'd1;
        i_Column_Index = 8'd2;
        i_Result_Taken = 1'b0;
        load_3x3();
        tick();
        tick();
        n_checks++;
        if ({o_Result_Ready, o_Indexes_Received, o_Error, o_A_Addr, o_B_Addr, o_Result,
             o_Result_Row, o_Result_Column} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b ack=%b err=%b a=%0d b=%0d res=%h expected all 0",
                     o_Result_Ready, o_Indexes_Received, o_Error, o_A_Addr, o_B_Addr, o_Result);
        end
        // Release and request together: first edge after release captures.
        i_Reset = 1'b1;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        n_checks++;
        if (o_Indexes_Received !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_capture: ack=%b expected 1", o_Indexes_Received);
        end
        repeat (4) tick();
        n_checks++;
        if (o_Result_Ready !== 1'b1 || o_Result !== 32'd96) begin
            n_fail++;
            $display("FAIL reset_first_job: ready=%b res=%0d expected 1/96", o_Result_Ready,
                     o_Result);
        end
        take_result();
    endtask

    task automatic test_basic();
        logic [15:0] exp_a [0:2];
        logic [15:0] exp_b [0:2];
        exp_a[0] = 16'd3; exp_a[1] = 16'd4; exp_a[2] = 16'd5;
        exp_b[0] = 16'd2; exp_b[1] = 16'd5; exp_b[2] = 16'd8;
        load_3x3();
        i_Row_Index = 8'd1;
        i_Column_Index = 8'd2;
        i_Indexes_Ready = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            i_Indexes_Ready = 4'b0000;
            n_checks++;
            if (o_Indexes_Received !== (k == 0)) begin
                n_fail++;
                $display("FAIL basic_ack k=%0d: ack=%b expected %b", k, o_Indexes_Received,
                         (k == 0));
            end
            n_checks++;
            if (o_A_Addr !== exp_a[k] || o_B_Addr !== exp_b[k]) begin
                n_fail++;
                $display("FAIL basic_addr k=%0d: a=%0d b=%0d expected %0d/%0d", k, o_A_Addr,
                         o_B_Addr, exp_a[k], exp_b[k]);
            end
        end
        tick();
        n_checks++;
        if (o_Result_Ready !== 1'b0 || o_A_Addr !== 16'd0) begin
            n_fail++;
            $display("FAIL basic_drain: ready=%b a=%0d expected 0/0", o_Result_Ready, o_A_Addr);
        end
        tick();
        n_checks++;
        if ({o_Result_Ready, o_Result, o_Result_Row, o_Result_Column, o_Error} !==
            {1'b1, 32'd96, 8'd1, 8'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: ready=%b res=%0d row=%0d col=%0d err=%b expected 1/96/1/2/0",
                     o_Result_Ready, o_Result, o_Result_Row, o_Result_Column, o_Error);
        end
        take_result();
        n_checks++;
        if (o_Result_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_taken: ready=%b expected 0", o_Result_Ready);
        end
    endtask

    task automatic test_hold();
        load_3x3();
        i_Row_Index = 8'd0;
        i_Column_Index = 8'd0;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        // Changing config and indexes after capture must not affect the job.
        i_Config = 32'hFFFF_FFFF;
        i_Row_Index = 8'd7;
        i_Column_Index = 8'd9;
        repeat (4) tick();
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({o_Result_Ready, o_Result, o_Result_Row, o_Result_Column, o_Error} !==
                {1'b1, 32'd30, 8'd0, 8'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_stable c=%0d: ready=%b res=%0d row=%0d col=%0d err=%b expected 1/30/0/0/0",
                         c, o_Result_Ready, o_Result, o_Result_Row, o_Result_Column, o_Error);
            end
            tick();
        end
        take_result();
        n_checks++;
        if (o_Result_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_taken: ready=%b expected 0", o_Result_Ready);
        end
        i_Config = 32'h0303_0303;
        i_Row_Index = 8'd1;
        i_Column_Index = 8'd2;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        n_checks++;
        if (o_Indexes_Received !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_next_capture: ack=%b expected 1", o_Indexes_Received);
        end
        repeat (4) tick();
        n_checks++;
        if (o_Result_Ready !== 1'b1 || o_Result !== 32'd96) begin
            n_fail++;
            $display("FAIL hold_next_result: ready=%b res=%0d expected 1/96", o_Result_Ready,
                     o_Result);
        end
        take_result();
    endtask

    task automatic test_out_of_range();
        load_3x3();
        i_Row_Index = 8'd3;
        i_Column_Index = 8'd0;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        n_checks++;
        if (o_Indexes_Received !== 1'b1 || o_A_Addr !== 16'd0 || o_B_Addr !== 16'd0) begin
            n_fail++;
            $display("FAIL oor_capture: ack=%b a=%0d b=%0d expected 1/0/0", o_Indexes_Received,
                     o_A_Addr, o_B_Addr);
        end
        tick();
        n_checks++;
        if ({o_Result_Ready, o_Error, o_Result, o_A_Addr} !== {1'b1, 1'b1, 32'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL oor_result: ready=%b err=%b res=%0d a=%0d expected 1/1/0/0",
                     o_Result_Ready, o_Error, o_Result, o_A_Addr);
        end
        take_result();
        // Inner dimension mismatch with in-range indexes.
        i_Config = 32'h0303_0203;
        i_Row_Index = 8'd0;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        tick();
        n_checks++;
        if ({o_Result_Ready, o_Error, o_Result} !== {1'b1, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL kmismatch_result: ready=%b err=%b res=%0d expected 1/1/0",
                     o_Result_Ready, o_Error, o_Result);
        end
        take_result();
    endtask

    task automatic test_k_zero();
        load_3x3();
        i_Config = 32'h0300_0003;
        i_Row_Index = 8'd1;
        i_Column_Index = 8'd1;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        n_checks++;
        if (o_Indexes_Received !== 1'b1 || o_Result_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL kzero_capture: ack=%b ready=%b expected 1/0", o_Indexes_Received,
                     o_Result_Ready);
        end
        tick();
        n_checks++;
        if ({o_Result_Ready, o_Error, o_Result} !== {1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL kzero_result: ready=%b err=%b res=%0d expected 1/0/0",
                     o_Result_Ready, o_Error, o_Result);
        end
        take_result();
    endtask

    task automatic test_other_bit();
        load_3x3();
        i_Row_Index = 8'd1;
        i_Column_Index = 8'd1;
        i_Indexes_Ready = 4'b1110;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (o_Indexes_Received !== 1'b0 || o_Result_Ready !== 1'b0) begin
                n_fail++;
                $display("FAIL other_bit c=%0d: ack=%b ready=%b expected 0/0", c,
                         o_Indexes_Received, o_Result_Ready);
            end
        end
        i_Indexes_Ready = 4'b0000;
        // Result-taken while idle must not disturb anything.
        i_Result_Taken = 1'b1;
        tick();
        i_Result_Taken = 1'b0;
    endtask

    task automatic test_busy_ignore();
        bit seen;
        load_3x3();
        i_Row_Index = 8'd1;
        i_Column_Index = 8'd2;
        i_Indexes_Ready = 4'b0001;
        tick();
        n_checks++;
        if (o_Indexes_Received !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first_ack: ack=%b expected 1", o_Indexes_Received);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (o_Indexes_Received !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_no_ack c=%0d: ack=%b expected 0", c, o_Indexes_Received);
            end
        end
        n_checks++;
        if (o_Result_Ready !== 1'b1 || o_Result !== 32'd96) begin
            n_fail++;
            $display("FAIL busy_result: ready=%b res=%0d expected 1/96", o_Result_Ready,
                     o_Result);
        end
        take_result();
        seen = 1'b0;
        for (int c = 0; c < 3 && !seen; c++) begin
            if (o_Indexes_Received === 1'b1) seen = 1'b1;
            else tick();
        end
        i_Indexes_Ready = 4'b0000;
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_held_capture: ack seen=%b expected 1", seen);
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (o_Result_Ready === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1 || o_Result !== 32'd96) begin
            n_fail++;
            $display("FAIL busy_held_result: ready=%b res=%0d expected 1/96", seen, o_Result);
        end
        take_result();
    endtask

    task automatic test_reset_mid_job();
        load_3x3();
        i_Row_Index = 8'd2;
        i_Column_Index = 8'd1;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        tick();
        n_checks++;
        if (o_A_Addr !== 16'd7 || o_B_Addr !== 16'd4) begin
            n_fail++;
            $display("FAIL rst_mid_addr: a=%0d b=%0d expected 7/4", o_A_Addr, o_B_Addr);
        end
        i_Reset = 1'b0;
        #1;
        n_checks++;
        if ({o_Result_Ready, o_Indexes_Received, o_Error, o_A_Addr, o_B_Addr, o_Result,
             o_Result_Row, o_Result_Column} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: ready=%b ack=%b a=%0d b=%0d res=%h expected all 0",
                     o_Result_Ready, o_Indexes_Received, o_A_Addr, o_B_Addr, o_Result);
        end
        tick();
        i_Reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (o_Result_Ready !== 1'b0 || o_Indexes_Received !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_abandon c=%0d: ready=%b ack=%b expected 0/0", c,
                         o_Result_Ready, o_Indexes_Received);
            end
        end
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        repeat (4) tick();
        n_checks++;
        if ({o_Result_Ready, o_Result, o_Result_Row, o_Result_Column} !==
            {1'b1, 32'd126, 8'd2, 8'd1}) begin
            n_fail++;
            $display("FAIL rst_mid_next_job: ready=%b res=%0d row=%0d col=%0d expected 1/126/2/1",
                     o_Result_Ready, o_Result, o_Result_Row, o_Result_Column);
        end
        take_result();
    endtask

    task automatic test_signed();
        // A = [-3 4] (1x2), B = [5; -6] (2x1): -15 + -24 = -39.
        i_Config = 32'h0102_0201;
        mem_a[0] = -32'sd3;
        mem_a[1] = 32'd4;
        mem_b[0] = 32'd5;
        mem_b[1] = -32'sd6;
        i_Row_Index = 8'd0;
        i_Column_Index = 8'd0;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        tick();
        n_checks++;
        if (o_A_Addr !== 16'd1 || o_B_Addr !== 16'd1) begin
            n_fail++;
            $display("FAIL signed_addr: a=%0d b=%0d expected 1/1", o_A_Addr, o_B_Addr);
        end
        tick();
        tick();
        n_checks++;
        if (o_Result_Ready !== 1'b1 || o_Result !== 32'hFFFF_FFD9) begin
            n_fail++;
            $display("FAIL signed_result: ready=%b res=%h expected 1/ffffffd9", o_Result_Ready,
                     o_Result);
        end
        take_result();
    endtask

    task automatic test_saturate();
        logic [31:0] exp_res;
`ifdef WORKER_SATURATE_EN
        exp_res = 32'h7FFF_FFFF;
`else
        exp_res = 32'hFFFF_FFFE;
`endif
        i_Config = 32'h0101_0101;
        mem_a[0] = 32'h7FFF_FFFF;
        mem_b[0] = 32'd2;
        i_Row_Index = 8'd0;
        i_Column_Index = 8'd0;
        i_Indexes_Ready = 4'b0001;
        tick();
        i_Indexes_Ready = 4'b0000;
        tick();
        n_checks++;
        if (o_Result_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_latency: ready=%b expected 0 at C+2", o_Result_Ready);
        end
        tick();
        n_checks++;
        if (o_Result_Ready !== 1'b1 || o_Result !== exp_res) begin
            n_fail++;
            $display("FAIL sat_result: ready=%b res=%h expected 1/%h", o_Result_Ready, o_Result,
                     exp_res);
        end
        take_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_out_of_range();
        test_k_zero();
        test_other_bit();
        test_busy_ignore();
        test_reset_mid_job();
        test_signed();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/worker_unit.md
WORKER_UNIT -- requirements
Module: worker_unit

Interface
REQ-001 Parameters SHALL be:
- UNIT_ID, default 0: selects which i_Indexes_Ready bit this unit answers.
- ADDR_W, default 16: memory address width.
REQ-002 Ports SHALL be, clock and reset first:
- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_Config  in  32  [31:24] A rows, [23:16] A cols (K), [15:8] B rows, [7:0] B cols.
- i_Indexes_Ready  in  4  one request bit per unit.
- i_Row_Index  in  8  requested C row.
- i_Column_Index  in  8  requested C column.
- o_Indexes_Received  out  1  one-cycle acknowledge of index capture.
- o_A_Addr  out  ADDR_W  A read address.
- i_A_Data  in  32  A read data, valid exactly 1 cycle after address.
- o_B_Addr  out  ADDR_W  B read address.
- i_B_Data  in  32  B read data, valid exactly 1 cycle after address.
- o_Result  out  32  C[row][col].
- o_Result_Row  out  8  row tag.
- o_Result_Column  out  8  column tag.
- o_Result_Ready  out  1  result valid, held until taken.
- i_Result_Taken  in  1  consumer accepts result.
- o_Error  out  1  indexes out of range; valid with o_Result_Ready.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
REQ-004 IDLE: if i_Indexes_Ready[UNIT_ID]=1 at edge C, the unit SHALL latch row, column and i_Config.
- o_Indexes_Received SHALL be 1 during cycle C+1 only.
- The unit SHALL go to FETCH.
REQ-005 Config and indexes SHALL be sampled only at capture; later changes SHALL have no effect on the current job.
REQ-006 FETCH, for k = 0..K-1, one per cycle over cycles C+1..C+K:
- o_A_Addr SHALL be row*K + k.
- o_B_Addr SHALL be k*Bcols + col.
- Address arithmetic SHALL be unsigned, truncated to ADDR_W.
REQ-007 The accumulator SHALL clear at capture.
- Each returned pair SHALL add i_A_Data*i_B_Data, as signed 32x32 multiplication with the low 32 bits kept.
- Accumulation SHALL wrap modulo 2^32.
REQ-008 DRAIN SHALL last one cycle and absorb the final pair; o_Result_Ready SHALL rise at cycle C+K+2.
REQ-009 DONE: o_Result, o_Result_Row, o_Result_Column, o_Error and o_Result_Ready SHALL hold stable until i_Result_Taken=1 is sampled.
- The edge that samples i_Result_Taken=1 SHALL clear o_Result_Ready and enter IDLE.
REQ-010 K=0 SHALL skip FETCH:
- o_Result=0.
- o_Result_Ready rises at C+2.
REQ-011 Out-of-range indexes SHALL skip FETCH, with no memory addresses driven and ready at C+2:
- Out of range means row >= A rows or col >= B cols.
- Response: o_Error=1, o_Result=0.
REQ-012 A cols != B rows SHALL be treated as out of range, per REQ-011.
REQ-013 i_Indexes_Ready[UNIT_ID] outside IDLE SHALL be ignored, with no acknowledge.
- A request still held when the unit re-enters IDLE SHALL be captured on that edge.
REQ-014 i_Result_Taken outside DONE SHALL be ignored.
REQ-015 Other i_Indexes_Ready bits SHALL never affect the unit.

Reset
REQ-016 i_Reset=0 SHALL immediately, asynchronously to clock, force IDLE and zero every output and the accumulator.
REQ-017 Reset during FETCH, DRAIN or DONE SHALL abandon the job; no result or acknowledge SHALL appear after release.
REQ-018 The first capture after release SHALL be possible on the first rising edge with i_Reset=1.

Configuration
REQ-019 Macro WORKER_SATURATE_EN:
- When defined, each accumulate SHALL saturate to the signed 32-bit limits, 0x7FFFFFFF and 0x80000000, and the product SHALL be computed at full 64-bit width before saturation.
- When undefined, REQ-007 wrap behaviour SHALL apply.
- Latency SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Config 0x03030303, UNIT_ID=0, request bit0 with row=1, col=2, A=[1..9] row-major, B=[1..9] row-major -> ack at C+1; A addrs 3,4,5; B addrs 2,5,8; o_Result=96 and ready at C+5, tags 1/2; o_Error=0.
- Same job with i_Result_Taken held low 10 cycles -> outputs stable throughout; clears on the edge that samples Taken; a new request bit0 on the next edge is captured.
- Row=3, col=0 with config 0x03030303 -> no addresses driven; o_Error=1; o_Result=0; ready at C+2.
- Request bit1 only -> unit 0 never acknowledges; request bit0 during FETCH -> ignored until IDLE.
- i_Reset=0 pulse at C+2 of a 3x3 job -> all outputs 0 immediately; no ready after release; the next job completes correctly.
- K=1, A=0x7FFFFFFF, B=2 -> o_Result=0xFFFFFFFE without the macro; 0x7FFFFFFF with WORKER_SATURATE_EN.
